// File: rtl/bubble_sort_pkg.sv
// Shared types and defaults for the bubble sort controller.
// Optional early exit is enabled by defining BUBBLE_SORT_EARLY_EXIT_EN.
package bubble_sort_pkg;

    localparam int DATAWIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Index width for DEPTH entries; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Element stream interface: upstream load channel and downstream sorted-output channel.
// valid/ready: a beat transfers on a rising edge where valid && ready; the source holds
// data stable while valid is high and ready is low.
interface bubble_sort_ctrl_if #(
    parameter int DATAWIDTH = bubble_sort_pkg::DATAWIDTH_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bubble_sort_ctrl_dp_cmp_swap.sv
// Compare-and-order datapath: two 2:1 muxes steered by an unsigned a > b compare.
module dp_cmp_swap #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 swap,
    output logic [DATAWIDTH-1:0] lo,
    output logic [DATAWIDTH-1:0] hi
);
    // Strict greater-than keeps equal elements in place, so the sort is stable.
    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;
endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble sort job controller: LOAD DEPTH elements, SORT one compare per cycle, DRAIN ascending.
// Define BUBBLE_SORT_EARLY_EXIT_EN to end SORT after the first pass with no swaps.
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF      // legal range 2..64
) (
    input  logic               clk,
    input  logic               rst_n,
    bubble_sort_ctrl_if.slave  bus,
    output logic               busy,
    output logic               swap_sel,
    output state_t             state_dbg
);
    localparam int             IW       = clog2(DEPTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0]  LAST_J0  = IW'(DEPTH - 2);

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        j_q;
    logic [IW-1:0]        p_q;
    logic [IW-1:0]        j1;
    logic                 cmp_swap;
    logic [DATAWIDTH-1:0] cmp_lo, cmp_hi;
    logic                 pass_end;
    logic                 last_pass;
    logic                 sort_done;
    logic                 in_rdy;
    logic                 out_vld;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    logic                 pass_swapped_q;
`endif

    assign j1 = j_q + 1'b1;

    dp_cmp_swap #(.DATAWIDTH(DATAWIDTH)) u_cmp (
        .a    (mem_q[j_q]),
        .b    (mem_q[j1]),
        .swap (cmp_swap),
        .lo   (cmp_lo),
        .hi   (cmp_hi)
    );

    // Pass p compares j = 0 .. DEPTH-2-p.
    assign pass_end  = (j_q == (LAST_J0 - p_q));
    assign last_pass = (p_q == LAST_J0);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    assign sort_done = pass_end && (last_pass || !(pass_swapped_q || cmp_swap));
`else
    assign sort_done = pass_end && last_pass;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        busy     = 1'b1;
        swap_sel = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy = 1'b1;
                busy   = 1'b0;
                if (bus.in_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_rdy = 1'b1;
                if (bus.in_valid && (idx_q == LAST_IDX)) state_d = ST_SORT;
            end
            ST_SORT: begin
                swap_sel = cmp_swap;
                if (sort_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_vld = 1'b1;
                if (bus.out_ready && (idx_q == LAST_IDX)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = (state_q == ST_DRAIN) ? mem_q[idx_q] : '0;
    assign state_dbg     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            idx_q <= '0;
            j_q   <= '0;
            p_q   <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            pass_swapped_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mem_q[0] <= bus.in_data;
                        idx_q    <= IW'(1);
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        mem_q[idx_q] <= bus.in_data;
                        idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        j_q          <= '0;
                        p_q          <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped_q <= 1'b0;
`endif
                    end
                end
                ST_SORT: begin
                    // Writing the ordered pair back is the swap when cmp_swap is set.
                    mem_q[j_q] <= cmp_lo;
                    mem_q[j1]  <= cmp_hi;
                    if (pass_end) begin
                        j_q <= '0;
                        p_q <= p_q + 1'b1;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped_q <= 1'b0;
`endif
                    end else begin
                        j_q <= j1;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped_q <= pass_swapped_q | cmp_swap;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: vector table of sort jobs, mid-SORT reset, random jobs.
module tb_bubble_sort_ctrl;
  import bubble_sort_pkg::*;

  localparam int W = 8;
  localparam int N = 8;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  localparam int ASC_CYC = 7;
  localparam int R21_CYC = 18;
  localparam int RND_CYC = -1;
`else
  localparam int ASC_CYC = 28;
  localparam int R21_CYC = 28;
  localparam int RND_CYC = 28;
`endif

  typedef struct {
    logic [W-1:0] din [N];
    logic [W-1:0] dout [N];
    int           sort_cyc;   // -1: not checked
    int           swaps;
    int           gap;
    int           rdy_mode;   // 0: always ready, 1: ready pattern 1,0,0
    bit           hold_valid;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bubble_sort_ctrl_if #(.DATAWIDTH(W)) bif ();
  logic   busy;
  logic   swap_sel;
  state_t state_dbg;

  bubble_sort_ctrl #(.DATAWIDTH(W), .DEPTH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif),
    .busy      (busy),
    .swap_sel  (swap_sel),
    .state_dbg (state_dbg)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int sort_cyc, swap_cnt, acc_cnt, out_cnt;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // scoreboard / monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (state_dbg == ST_SORT) sort_cyc++;
      if (swap_sel) swap_cnt++;
      if (state_dbg != ST_SORT) chk("swap_sel_outside_sort", swap_sel, 0);
      if (bif.in_valid && bif.in_ready) acc_cnt++;
      if (prev_stall) begin
        chk("stall_valid_held", bif.out_valid, 1);
        chk("stall_data_held", bif.out_data, prev_data);
      end
      if (bif.out_valid && bif.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else chk("out_data", bif.out_data, exp_q.pop_front());
      end
      prev_stall = bif.out_valid && !bif.out_ready;
      prev_data  = bif.out_data;
    end
  end

  // driver tasks
  task automatic load_job(input vec_t v);
    sort_cyc = 0;
    swap_cnt = 0;
    acc_cnt  = 0;
    out_cnt  = 0;
    for (int i = 0; i < N; i++) begin
      int guard;
      bit acc;
      guard = 0;
      acc   = 1'b0;
      bif.in_data  = v.din[i];
      bif.in_valid = 1'b1;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = bif.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) fail_now("load_timeout");
      if (v.gap > 0) begin
        bif.in_valid = 1'b0;
        repeat (v.gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (v.hold_valid) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'hEE;
    end else begin
      bif.in_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(v.dout[i]);
  endtask

  task automatic drain_and_check(input vec_t v, input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(posedge clk);
      #1;
      bif.out_ready = (v.rdy_mode == 0) ? 1'b1 : ((guard % 3) == 0);
      if (exp_q.size() <= 1) bif.in_valid = 1'b0;
      guard++;
    end
    if (exp_q.size() > 0) fail_now({tag, "_drain_timeout"});
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b0;
    @(negedge clk);
    chk({tag, "_state_idle"}, state_dbg, ST_IDLE);
    chk({tag, "_in_ready"}, bif.in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_accepted"}, acc_cnt, N);
    chk({tag, "_out_count"}, out_cnt, N);
    chk({tag, "_swap_count"}, swap_cnt, v.swaps);
    if (v.sort_cyc >= 0) chk({tag, "_sort_cycles"}, sort_cyc, v.sort_cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic make_random(output vec_t v);
    logic [W-1:0] t;
    int inv;
    for (int i = 0; i < N; i++) begin
      v.din[i]  = W'($urandom_range(0, 255));
      v.dout[i] = v.din[i];
    end
    // insertion sort as the reference ordering
    for (int i = 1; i < N; i++) begin
      for (int k = i; k > 0; k--) begin
        if (v.dout[k-1] > v.dout[k]) begin
          t = v.dout[k];
          v.dout[k] = v.dout[k-1];
          v.dout[k-1] = t;
        end
      end
    end
    inv = 0;
    for (int i = 0; i < N; i++)
      for (int k = i + 1; k < N; k++)
        if (v.din[i] > v.din[k]) inv++;
    v.swaps      = inv;
    v.sort_cyc   = RND_CYC;
    v.gap        = int'($urandom_range(0, 1));
    v.rdy_mode   = int'($urandom_range(0, 1));
    v.hold_valid = 1'b0;
  endtask

  vec_t tbl [4];
  vec_t vr;

  initial begin
    tbl[0].din = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].dout = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[0].sort_cyc = 28; tbl[0].swaps = 28; tbl[0].gap = 0; tbl[0].rdy_mode = 0; tbl[0].hold_valid = 0;
    tbl[1].din = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[1].dout = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[1].sort_cyc = ASC_CYC; tbl[1].swaps = 0; tbl[1].gap = 0; tbl[1].rdy_mode = 0; tbl[1].hold_valid = 0;
    tbl[2].din = '{8'd5, 8'd5, 8'd3, 8'd5, 8'd3, 8'd3, 8'd9, 8'd0};
    tbl[2].dout = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd5, 8'd5, 8'd5, 8'd9};
    tbl[2].sort_cyc = 28; tbl[2].swaps = 15; tbl[2].gap = 0; tbl[2].rdy_mode = 1; tbl[2].hold_valid = 0;
    tbl[3].din = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[3].dout = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    tbl[3].sort_cyc = R21_CYC; tbl[3].swaps = 13; tbl[3].gap = 2; tbl[3].rdy_mode = 0; tbl[3].hold_valid = 1;

    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_sel", swap_sel, 0);
    chk("rst_out_data", bif.out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      load_job(tbl[t]);
      drain_and_check(tbl[t], $sformatf("vec%0d", t));
    end

    // reset in the middle of SORT, then a fresh job
    begin
      int guard;
      guard = 0;
      load_job(tbl[0]);
      while (sort_cyc < 10 && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      if (sort_cyc < 10) fail_now("reach_sort_timeout");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", state_dbg, ST_IDLE);
      chk("midrst_in_ready", bif.in_ready, 1);
      chk("midrst_out_valid", bif.out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_swap_sel", swap_sel, 0);
      chk("midrst_out_data", bif.out_data, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vr = tbl[3];
      vr.gap = 0;
      vr.hold_valid = 1'b0;
      load_job(vr);
      drain_and_check(vr, "post_reset");
    end

    for (int r = 0; r < 3; r++) begin
      make_random(vr);
      load_job(vr);
      drain_and_check(vr, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench time limit expired");
  end

endmodule
